// File: rtl/rst_seq_gen_pkg.sv
// Shared types for the reset/clock-enable sequencer.
// Holds the FSM state encoding (3-bit) and the default counter width.
package rst_seq_gen_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // States in which a sequence is considered in progress
  function automatic logic is_busy(input state_t s);
    return (s == ST_HOLD) || (s == ST_RELEASE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/rst_seq_gen_seq_cnt.sv
// seq_cnt: loadable saturating down-counter with a zero flag.
// Load has priority over decrement; a decrement at zero holds zero.
module seq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Count register: reload, or step down and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered per-domain reset release followed by a gated
// clock-enable burst. Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
// One shared down-counter times the hold phase, each stagger gap and the
// burst; all outputs come straight from registers.
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int RST_HOLD  = 2,
  parameter int STAGGER   = 4,
  parameter int BURST_LEN = 99,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              pause_i,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              clk_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] STAG_LD  = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(BURST_LEN - 1);

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] ch_rst_reg, ch_rst_next;
  logic [IDX_W-1:0]  ch_idx_reg, ch_idx_next;
  logic              clk_en_reg, clk_en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;

  seq_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef SEQ_WATCHDOG_EN
  logic wd_load, wd_zero;
  logic timeout_reg, timeout_next;

  // A sequence start restarts the busy-cycle budget
  assign wd_load = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start_i;

  seq_cnt #(.CNT_W(CNT_W)) u_wd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (CNT_W'(TIMEOUT - 1)),
    .dec      (busy_reg),
    .zero     (wd_zero)
  );

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_next;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

  // Next state, channel resets and counter control; abort overrides all
  always_comb begin
    state_next   = state_reg;
    ch_rst_next  = ch_rst_reg;
    ch_idx_next  = ch_idx_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    timeout_next = timeout_reg;
`endif

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_next   = ST_HOLD;
          ch_rst_next  = '1;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_next   = ST_RELEASE;
          ch_idx_next  = '0;
          cnt_load     = 1'b1;
          cnt_load_val = STAG_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_zero) begin
          if (!ch_rst_reg[NUM_CH-1]) begin
            // Last channel already released one cycle ago: start the burst
            state_next   = ST_RUN;
            cnt_load     = 1'b1;
            cnt_load_val = BURST_LD;
          end else begin
            ch_rst_next[ch_idx_reg] = 1'b0;
            cnt_load = 1'b1;
            if (ch_idx_reg == LAST_IDX) begin
              // Zero reload gives exactly one settle cycle before RUN
              cnt_load_val = '0;
            end else begin
              cnt_load_val = STAG_LD;
              ch_idx_next  = ch_idx_reg + 1'b1;
            end
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        // Only enabled cycles consume the burst; paused cycles hold it
        if (clk_en_reg) begin
          if (cnt_zero) begin
            state_next = ST_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        ch_rst_next = '1;
      end
    endcase

`ifdef SEQ_WATCHDOG_EN
    if (wd_load) begin
      timeout_next = 1'b0;
    end
    if (busy_reg && wd_zero) begin
      state_next   = ST_IDLE;
      ch_rst_next  = '1;
      timeout_next = 1'b1;
    end
`endif

    if (abort_i && (state_reg != ST_IDLE)) begin
      state_next  = ST_IDLE;
      ch_rst_next = '1;
`ifdef SEQ_WATCHDOG_EN
      timeout_next = timeout_reg;
`endif
    end

    clk_en_next = (state_next == ST_RUN) && !pause_i;
    busy_next   = is_busy(state_next);
    done_next   = (state_next == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      ch_rst_reg <= '1;
      ch_idx_reg <= '0;
      clk_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ch_rst_reg <= ch_rst_next;
      ch_idx_reg <= ch_idx_next;
      clk_en_reg <= clk_en_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign ch_rst_o = ch_rst_reg;
  assign clk_en_o = clk_en_reg;
  assign busy_o   = busy_reg;
  assign done_o   = done_reg;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen (defaults NUM_CH=4, RST_HOLD=2, STAGGER=4,
// BURST_LEN=99). Timeline relative to the cycle start_i is sampled (r=0):
// busy at r=1, ch_rst 1110/1100/1000/0000 at r=7/11/15/19, clk_en r=20..118,
// done at r=119. Watchdog checks run on a second instance when
// SEQ_WATCHDOG_EN is defined.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0, abort_i = 1'b0, pause_i = 1'b0;
  logic [3:0] ch_rst_o;
  logic       clk_en_o, busy_o, done_o, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_CH(4), .RST_HOLD(2), .STAGGER(4), .BURST_LEN(99), .CNT_W(16), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .pause_i(pause_i),
    .ch_rst_o(ch_rst_o), .clk_en_o(clk_en_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o)
  );

`ifdef SEQ_WATCHDOG_EN
  logic       w_start = 1'b0, w_abort = 1'b0, w_pause = 1'b0;
  logic [3:0] w_ch_rst;
  logic       w_clk_en, w_busy, w_done, w_timeout;

  rst_seq_gen #(
    .NUM_CH(4), .RST_HOLD(2), .STAGGER(4), .BURST_LEN(99), .CNT_W(16), .TIMEOUT(50)
  ) dut_wd (
    .clk(clk), .rst(rst), .start_i(w_start), .abort_i(w_abort), .pause_i(w_pause),
    .ch_rst_o(w_ch_rst), .clk_en_o(w_clk_en), .busy_o(w_busy), .done_o(w_done),
    .timeout_o(w_timeout)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ch"}, 32'(ch_rst_o), 32'hF);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_en"}, 32'(clk_en_o), 32'h0);
  endtask

  // Full sequence from a start pulse; optional pause window and a spurious
  // start while busy (spur_at=0 disables it)
  task automatic run_seq(input string tag, input int pause_at, input int pause_len,
                         input int spur_at);
    int r, en_cnt, first_en, low_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    r = 1;
    chk({tag, "_busy_r1"}, 32'(busy_o), 32'h1);
    chk({tag, "_ch_r1"}, 32'(ch_rst_o), 32'hF);
    chk({tag, "_done_r1"}, 32'(done_o), 32'h0);
    chk({tag, "_to_r1"}, 32'(timeout_o), 32'h0);
    en_cnt = 0; first_en = 0; low_cnt = 0;
    while (!done_o && r < 400) begin
      pause_i = (pause_len > 0) && (r >= pause_at) && (r < pause_at + pause_len);
      start_i = (r == spur_at);
      tick();
      r++;
      case (r)
        6:  chk({tag, "_ch_r6"},  32'(ch_rst_o), 32'hF);
        7:  chk({tag, "_ch_r7"},  32'(ch_rst_o), 32'hE);
        10: chk({tag, "_ch_r10"}, 32'(ch_rst_o), 32'hE);
        11: chk({tag, "_ch_r11"}, 32'(ch_rst_o), 32'hC);
        15: chk({tag, "_ch_r15"}, 32'(ch_rst_o), 32'h8);
        19: chk({tag, "_ch_r19"}, 32'(ch_rst_o), 32'h0);
        default: ;
      endcase
      if (clk_en_o) begin
        en_cnt++;
        if (first_en == 0) first_en = r;
      end else if (first_en != 0 && !done_o) begin
        low_cnt++;
      end
    end
    pause_i = 1'b0;
    start_i = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_o), 32'h1);
    chk({tag, "_done_cycle"}, 32'(r), 32'(119 + pause_len));
    chk({tag, "_first_en"}, 32'(first_en), 32'd20);
    chk({tag, "_en_cnt"}, 32'(en_cnt), 32'd99);
    chk({tag, "_paused"}, 32'(low_cnt), 32'(pause_len));
    chk({tag, "_busy_done"}, 32'(busy_o), 32'h0);
    chk({tag, "_en_done"}, 32'(clk_en_o), 32'h0);
    chk({tag, "_ch_done"}, 32'(ch_rst_o), 32'h0);
    $display("%s: done at r=%0d, enabled=%0d, paused=%0d", tag, r, en_cnt, low_cnt);
  endtask

  initial begin
    // Reset values while rst is held
    #2 rst = 1'b1;
    #1;
    chk("rst_ch", 32'(ch_rst_o), 32'hF);
    chk("rst_en", 32'(clk_en_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_to", 32'(timeout_o), 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (9) tick();
    chk_idle("idle_pre");
    $display("reset: outputs at reset values");

    // 1: nominal sequence, then DONE holds
    run_seq("s1", 0, 0, 0);
    repeat (3) tick();
    chk("s1_done_hold", 32'(done_o), 32'h1);
    chk("s1_ch_hold", 32'(ch_rst_o), 32'h0);

    // abort in DONE returns to IDLE; abort in IDLE then does nothing
    abort_i = 1'b1;
    tick();
    chk_idle("s1_abort");
    tick();
    abort_i = 1'b0;
    chk_idle("idle_abort");
    $display("abort: DONE->IDLE, no effect in IDLE");

    // 2: 10-cycle pause mid-RUN plus an ignored start while busy
    run_seq("s2", 50, 10, 30);

    // 3: abort during RELEASE at ch_rst=1100, then replay
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    chk("s3_ch_pre", 32'(ch_rst_o), 32'hC);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk_idle("s3_abort");
    tick();
    chk_idle("s3_stay");
    $display("s3: abort in RELEASE returned to IDLE");
    run_seq("s3r", 0, 0, 0);

    // 4: start and abort together in DONE
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk_idle("s4_abort");
    tick();
    chk_idle("s4_stay");
    $display("s4: abort beat start in DONE");

    // 6: async reset mid-RUN takes effect without a clock edge
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (39) tick();
    chk("s6_en_pre", 32'(clk_en_o), 32'h1);
    rst = 1'b1;
    #1;
    chk_idle("s6_async");
    #2 rst = 1'b0;
    tick();
    tick();
    chk_idle("s6_after");
    $display("s6: async reset mid-RUN");

`ifdef SEQ_WATCHDOG_EN
    // 5: watchdog with pause held; trip after 50 busy cycles
    w_pause = 1'b1;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    repeat (49) tick();
    chk("s5_busy_r50", 32'(w_busy), 32'h1);
    chk("s5_to_r50", 32'(w_timeout), 32'h0);
    chk("s5_ch_r50", 32'(w_ch_rst), 32'h0);
    tick();
    chk("s5_to_r51", 32'(w_timeout), 32'h1);
    chk("s5_ch_r51", 32'(w_ch_rst), 32'hF);
    chk("s5_busy_r51", 32'(w_busy), 32'h0);
    chk("s5_en_r51", 32'(w_clk_en), 32'h0);
    repeat (3) tick();
    chk("s5_sticky", 32'(w_timeout), 32'h1);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("s5_to_clr", 32'(w_timeout), 32'h0);
    chk("s5_busy_new", 32'(w_busy), 32'h1);
    w_abort = 1'b1;
    tick();
    w_abort = 1'b0;
    w_pause = 1'b0;
    chk("s5_abort", 32'(w_busy), 32'h0);
    $display("s5: watchdog trip and clear");
`else
    chk("s5_no_wd", 32'(timeout_o), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
